load_store_queue: RTL and testbench

- Parametrised successor to the single-channel load/store buffer: an in-order circular queue of memory ops between the dispatcher, the CDB, the RoB and the memory controller.
- Adds operand wake-up from the CDB and correct per-opcode width and sign/zero extension of load data.
- Keeps exactly one outstanding memory transaction.
- Adds flush-safe draining, so a committed store in flight always completes and a flushed load never writes back.

---
 rtl/lsq_pkg.sv | 43 ++++
 rtl/lsq_load_extend.sv | 21 ++
 rtl/load_store_queue.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_queue.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: opcode values, access width
// codes, FSM states and opcode decode helpers.
package lsq_pkg;

  localparam logic [6:0] OP_LB  = 7'd11;
  localparam logic [6:0] OP_LH  = 7'd12;
  localparam logic [6:0] OP_LW  = 7'd13;
  localparam logic [6:0] OP_LBU = 7'd14;
  localparam logic [6:0] OP_LHU = 7'd15;
  localparam logic [6:0] OP_SB  = 7'd16;
  localparam logic [6:0] OP_SH  = 7'd17;
  localparam logic [6:0] OP_SW  = 7'd18;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } lsq_state_e;

  function automatic logic op_is_store(input logic [6:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_zero_ext(input logic [6:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic [1:0] op_width(input logic [6:0] op);
    logic [1:0] w;
    case (op)
      OP_LB, OP_LBU, OP_SB: w = WIDTH_BYTE;
      OP_LH, OP_LHU, OP_SH: w = WIDTH_HALF;
      OP_LW, OP_SW:         w = WIDTH_WORD;
      default:              w = WIDTH_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsq_load_extend.sv
// Masks raw memory read data to the access width and sign/zero extends it.
module lsq_load_extend
  import lsq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_data,
  input  logic [1:0]      width,
  input  logic            zero_ext,
  output logic [XLEN-1:0] ext_data
);

  always_comb begin
    case (width)
      WIDTH_BYTE: ext_data = {{(XLEN-8){~zero_ext & raw_data[7]}}, raw_data[7:0]};
      WIDTH_HALF: ext_data = {{(XLEN-16){~zero_ext & raw_data[15]}}, raw_data[15:0]};
      default:    ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order circular load/store queue with CDB wake-up and a single outstanding
// memory transaction. Define LSQ_CDB_BYPASS_EN to capture same-cycle CDB values at dispatch.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int LSQ_WIDTH = 3,
  parameter int RoB_WIDTH = 3,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 new_entry_en,
  input  logic [RoB_WIDTH-1:0] new_entry_RoBIndex,
  input  logic [6:0]           new_entry_opcode,
  input  logic [XLEN-1:0]      new_entry_Vj,
  input  logic [XLEN-1:0]      new_entry_Vk,
  input  logic [RoB_WIDTH:0]   new_entry_Qj,
  input  logic [RoB_WIDTH:0]   new_entry_Qk,
  input  logic [XLEN-1:0]      new_entry_imm,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [XLEN-1:0]      cdb_data,
  input  logic [RoB_WIDTH:0]   RoB_headIndex,
  input  logic                 flush_signal,
  output logic                 mem_query_en,
  output logic                 mem_query_type,
  output logic [XLEN-1:0]      mem_query_addr,
  output logic [1:0]           mem_data_width,
  output logic [XLEN-1:0]      mem_query_data,
  input  logic                 mem_reply_en,
  input  logic [XLEN-1:0]      mem_reply_data,
  output logic                 RoB_write_en,
  output logic [RoB_WIDTH-1:0] RoB_write_index,
  output logic [XLEN-1:0]      RoB_write_data,
  output logic                 isFull,
  output logic [LSQ_WIDTH:0]   count
);

  localparam int LSQ_SIZE = 1 << LSQ_WIDTH;
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};
  localparam logic [LSQ_WIDTH:0] FULL_CNT = (LSQ_WIDTH+1)'(LSQ_SIZE);
  localparam logic [LSQ_WIDTH:0] CNT_ONE = (LSQ_WIDTH+1)'(1);
  localparam logic [LSQ_WIDTH-1:0] PTR_ONE = LSQ_WIDTH'(1);

  logic [LSQ_SIZE-1:0]  valid_q, valid_d, store_q, store_d, zext_q, zext_d;
  logic [1:0]           width_q [LSQ_SIZE];
  logic [1:0]           width_d [LSQ_SIZE];
  logic [RoB_WIDTH-1:0] tag_q [LSQ_SIZE];
  logic [RoB_WIDTH-1:0] tag_d [LSQ_SIZE];
  logic [XLEN-1:0]      vj_q [LSQ_SIZE];
  logic [XLEN-1:0]      vj_d [LSQ_SIZE];
  logic [XLEN-1:0]      vk_q [LSQ_SIZE];
  logic [XLEN-1:0]      vk_d [LSQ_SIZE];
  logic [XLEN-1:0]      imm_q [LSQ_SIZE];
  logic [XLEN-1:0]      imm_d [LSQ_SIZE];
  logic [RoB_WIDTH:0]   qj_q [LSQ_SIZE];
  logic [RoB_WIDTH:0]   qj_d [LSQ_SIZE];
  logic [RoB_WIDTH:0]   qk_q [LSQ_SIZE];
  logic [RoB_WIDTH:0]   qk_d [LSQ_SIZE];

  logic [LSQ_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [LSQ_WIDTH:0]   count_q, count_d;
  lsq_state_e           state_q, state_d;

  logic                 mq_en_q, mq_en_d, mq_type_q, mq_type_d;
  logic [XLEN-1:0]      mq_addr_q, mq_addr_d, mq_data_q, mq_data_d;
  logic [1:0]           mq_width_q, mq_width_d;
  logic                 rob_en_q, rob_en_d;
  logic [RoB_WIDTH-1:0] rob_idx_q, rob_idx_d;
  logic [XLEN-1:0]      rob_data_q, rob_data_d;

  logic                 enq, pop, head_ready;
  logic [RoB_WIDTH:0]   cdb_tag;
  logic [XLEN-1:0]      ext_data;

  lsq_load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw_data (mem_reply_data),
    .width    (width_q[head_q]),
    .zero_ext (zext_q[head_q]),
    .ext_data (ext_data)
  );

  assign isFull     = (count_q == FULL_CNT);
  assign cdb_tag    = {1'b0, cdb_index};
  assign head_ready = valid_q[head_q] && (qj_q[head_q] == NON_DEP) && (qk_q[head_q] == NON_DEP);
  assign enq        = new_entry_en && !isFull && !flush_signal;

  always_comb begin
    state_d = state_q;  head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    valid_d = valid_q;  store_d = store_q;  zext_d = zext_q;  width_d = width_q;
    tag_d = tag_q;  vj_d = vj_q;  vk_d = vk_q;  imm_d = imm_q;  qj_d = qj_q;  qk_d = qk_q;
    mq_en_d = mq_en_q;  mq_type_d = mq_type_q;  mq_addr_d = mq_addr_q;
    mq_width_d = mq_width_q;  mq_data_d = mq_data_q;
    rob_en_d = 1'b0;  rob_idx_d = rob_idx_q;  rob_data_d = rob_data_q;
    pop = 1'b0;

    if (cdb_en && !flush_signal) begin
      for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
        if (valid_q[i] && qj_q[i] == cdb_tag) begin vj_d[i] = cdb_data; qj_d[i] = NON_DEP; end
        if (valid_q[i] && qk_q[i] == cdb_tag) begin vk_d[i] = cdb_data; qk_d[i] = NON_DEP; end
      end
    end

    case (state_q)
      ST_IDLE: begin
        // Stores wait until the RoB reports them as the oldest uncommitted op.
        if (!flush_signal && head_ready &&
            (!store_q[head_q] || RoB_headIndex == {1'b0, tag_q[head_q]})) begin
          mq_en_d    = 1'b1;
          mq_type_d  = store_q[head_q];
          mq_addr_d  = vj_q[head_q] + imm_q[head_q];
          mq_width_d = width_q[head_q];
          mq_data_d  = store_q[head_q] ? vk_q[head_q] : '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_reply_en) begin
          mq_en_d = 1'b0;  mq_type_d = 1'b0;  mq_addr_d = '0;  mq_width_d = '0;  mq_data_d = '0;
          state_d = ST_IDLE;
          if (!flush_signal) begin
            rob_en_d   = 1'b1;
            rob_idx_d  = tag_q[head_q];
            rob_data_d = store_q[head_q] ? '0 : ext_data;
            pop        = 1'b1;
          end
        end else if (flush_signal) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_reply_en) begin
          mq_en_d = 1'b0;  mq_type_d = 1'b0;  mq_addr_d = '0;  mq_width_d = '0;  mq_data_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d = head_q + PTR_ONE;
    end

    if (enq) begin
      valid_d[tail_q] = 1'b1;
      store_d[tail_q] = op_is_store(new_entry_opcode);
      zext_d[tail_q]  = op_zero_ext(new_entry_opcode);
      width_d[tail_q] = op_width(new_entry_opcode);
      tag_d[tail_q]   = new_entry_RoBIndex;
      imm_d[tail_q]   = new_entry_imm;
      vj_d[tail_q]    = new_entry_Vj;
      vk_d[tail_q]    = new_entry_Vk;
      qj_d[tail_q]    = new_entry_Qj;
      qk_d[tail_q]    = new_entry_Qk;
`ifdef LSQ_CDB_BYPASS_EN
      if (cdb_en && new_entry_Qj == cdb_tag) begin vj_d[tail_q] = cdb_data; qj_d[tail_q] = NON_DEP; end
      if (cdb_en && new_entry_Qk == cdb_tag) begin vk_d[tail_q] = cdb_data; qk_d[tail_q] = NON_DEP; end
`endif
      tail_d = tail_q + PTR_ONE;
    end

    count_d = count_q + (enq ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

    // Flush empties the queue but never cancels the outstanding memory request.
    if (flush_signal) begin
      valid_d = '0;  head_d = '0;  tail_d = '0;  count_d = '0;
      for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
        qj_d[i] = NON_DEP;
        qk_d[i] = NON_DEP;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;  head_q <= '0;  tail_q <= '0;  count_q <= '0;
      valid_q <= '0;  store_q <= '0;  zext_q <= '0;
      for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
        width_q[i] <= '0;  tag_q[i] <= '0;  vj_q[i] <= '0;  vk_q[i] <= '0;  imm_q[i] <= '0;
        qj_q[i] <= NON_DEP;  qk_q[i] <= NON_DEP;
      end
      mq_en_q <= 1'b0;  mq_type_q <= 1'b0;  mq_addr_q <= '0;  mq_width_q <= '0;  mq_data_q <= '0;
      rob_en_q <= 1'b0;  rob_idx_q <= '0;  rob_data_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;  head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      valid_q <= valid_d;  store_q <= store_d;  zext_q <= zext_d;  width_q <= width_d;
      tag_q <= tag_d;  vj_q <= vj_d;  vk_q <= vk_d;  imm_q <= imm_d;  qj_q <= qj_d;  qk_q <= qk_d;
      mq_en_q <= mq_en_d;  mq_type_q <= mq_type_d;  mq_addr_q <= mq_addr_d;
      mq_width_q <= mq_width_d;  mq_data_q <= mq_data_d;
      rob_en_q <= rob_en_d;  rob_idx_q <= rob_idx_d;  rob_data_q <= rob_data_d;
    end
  end

  assign mem_query_en    = mq_en_q;
  assign mem_query_type  = mq_type_q;
  assign mem_query_addr  = mq_addr_q;
  assign mem_data_width  = mq_width_q;
  assign mem_query_data  = mq_data_q;
  assign RoB_write_en    = rob_en_q;
  assign RoB_write_index = rob_idx_q;
  assign RoB_write_data  = rob_data_q;
  assign count           = count_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Self-checking bench for load_store_queue: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_load_store_queue;

  localparam logic [3:0] ND = 4'd8;

  logic        clk, rst, rdy;
  logic        new_en;
  logic [2:0]  new_tag;
  logic [6:0]  new_op;
  logic [31:0] new_vj, new_vk, new_imm;
  logic [3:0]  new_qj, new_qk;
  logic        cdb_en;
  logic [2:0]  cdb_idx;
  logic [31:0] cdb_data;
  logic [3:0]  rob_head;
  logic        flush;
  logic        mem_query_en, mem_query_type;
  logic [31:0] mem_query_addr, mem_query_data;
  logic [1:0]  mem_data_width;
  logic        reply_en;
  logic [31:0] reply_data;
  logic        RoB_write_en;
  logic [2:0]  RoB_write_index;
  logic [31:0] RoB_write_data;
  logic        isFull;
  logic [3:0]  count;

  load_store_queue #(.LSQ_WIDTH(3), .RoB_WIDTH(3), .XLEN(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .new_entry_en(new_en), .new_entry_RoBIndex(new_tag), .new_entry_opcode(new_op),
    .new_entry_Vj(new_vj), .new_entry_Vk(new_vk), .new_entry_Qj(new_qj), .new_entry_Qk(new_qk),
    .new_entry_imm(new_imm), .cdb_en(cdb_en), .cdb_index(cdb_idx), .cdb_data(cdb_data),
    .RoB_headIndex(rob_head), .flush_signal(flush),
    .mem_query_en(mem_query_en), .mem_query_type(mem_query_type), .mem_query_addr(mem_query_addr),
    .mem_data_width(mem_data_width), .mem_query_data(mem_query_data),
    .mem_reply_en(reply_en), .mem_reply_data(reply_data),
    .RoB_write_en(RoB_write_en), .RoB_write_index(RoB_write_index), .RoB_write_data(RoB_write_data),
    .isFull(isFull), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  tag;
    logic [31:0] vj, vk, imm;
    logic [3:0]  qj, qk;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy, m_drain;
  logic        e_qen, e_qtype, e_wen;
  logic [1:0]  e_width;
  logic [31:0] e_addr, e_qdata, e_wdata;
  logic [2:0]  e_widx;

  function automatic bit is_st(input logic [6:0] op);
    return op >= 7'd16;
  endfunction

  function automatic logic [1:0] wid(input logic [6:0] op);
    if (op == 7'd11 || op == 7'd14 || op == 7'd16) return 2'd0;
    if (op == 7'd12 || op == 7'd15 || op == 7'd17) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [6:0] op);
    logic [31:0] r;
    bit unsigned_ld;
    unsigned_ld = (op == 7'd14 || op == 7'd15);
    r = raw;
    if (wid(op) == 2'd0) begin
      r = r & 32'h0000_00FF;
      if (!unsigned_ld && r >= 32'h80) r = r | 32'hFFFF_FF00;
    end else if (wid(op) == 2'd1) begin
      r = r & 32'h0000_FFFF;
      if (!unsigned_ld && r >= 32'h8000) r = r | 32'hFFFF_0000;
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0;  m_drain = 0;
    e_qen = 0;  e_qtype = 0;  e_width = 0;  e_addr = 0;  e_qdata = 0;
    e_wen = 0;  e_widx = 0;  e_wdata = 0;
  endtask

  task automatic model_step();
    int  sz0;
    bit  issue;
    ent_t n;
    if (!rdy) return;
    sz0 = mq.size();
    e_wen = 0;
    issue = !m_busy && !flush && sz0 > 0 && mq[0].qj == ND && mq[0].qk == ND &&
            (!is_st(mq[0].op) || rob_head == {1'b0, mq[0].tag});
    if (m_busy && reply_en) begin
      if (!m_drain) begin
        e_wen = 1;
        e_widx = mq[0].tag;
        e_wdata = is_st(mq[0].op) ? 32'h0 : ext(reply_data, mq[0].op);
        void'(mq.pop_front());
      end
      m_busy = 0;  m_drain = 0;
      e_qen = 0;  e_qtype = 0;  e_width = 0;  e_addr = 0;  e_qdata = 0;
    end
    if (issue) begin
      m_busy = 1;
      e_qen = 1;
      e_qtype = is_st(mq[0].op);
      e_addr = mq[0].vj + mq[0].imm;
      e_width = wid(mq[0].op);
      e_qdata = is_st(mq[0].op) ? mq[0].vk : 32'h0;
    end
    if (flush) begin
      mq.delete();
      if (m_busy) m_drain = 1;
    end else begin
      if (cdb_en) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].qj == {1'b0, cdb_idx}) begin mq[i].vj = cdb_data; mq[i].qj = ND; end
          if (mq[i].qk == {1'b0, cdb_idx}) begin mq[i].vk = cdb_data; mq[i].qk = ND; end
        end
      end
      if (new_en && sz0 < 8) begin
        n = '{op: new_op, tag: new_tag, vj: new_vj, vk: new_vk, imm: new_imm, qj: new_qj, qk: new_qk};
`ifdef LSQ_CDB_BYPASS_EN
        if (cdb_en && n.qj == {1'b0, cdb_idx}) begin n.vj = cdb_data; n.qj = ND; end
        if (cdb_en && n.qk == {1'b0, cdb_idx}) begin n.vk = cdb_data; n.qk = ND; end
`endif
        mq.push_back(n);
      end
    end
  endtask

  task automatic check_outputs();
    check("count", count, mq.size());
    check("isFull", isFull, mq.size() == 8);
    check("query_en", mem_query_en, e_qen);
    check("query_type", mem_query_type, e_qtype);
    check("query_addr", mem_query_addr, e_addr);
    check("query_width", mem_data_width, e_width);
    check("query_data", mem_query_data, e_qdata);
    check("rob_wen", RoB_write_en, e_wen);
    if (e_wen) begin
      check("rob_index", RoB_write_index, e_widx);
      check("rob_data", RoB_write_data, e_wdata);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    new_en = 0;  cdb_en = 0;  reply_en = 0;  flush = 0;
    check_outputs();
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [2:0] tag, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] imm,
                          input logic [3:0] qj, input logic [3:0] qk);
    new_en = 1;  new_op = op;  new_tag = tag;  new_vj = vj;  new_vk = vk;
    new_imm = imm;  new_qj = qj;  new_qk = qk;
  endtask

  task automatic reply(input logic [31:0] d);
    reply_en = 1;
    reply_data = d;
  endtask

  task automatic run_load(input string name, input logic [6:0] op, input logic [31:0] raw,
                          input logic [31:0] exp);
    dispatch(op, 3'd5, 32'h40, 32'h0, 32'h0, ND, ND);
    step();
    step();
    reply(raw);
    step();
    check(name, RoB_write_data, exp);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && (mq.size() > 0 || m_busy); k++) begin
      if (m_busy) reply($urandom);
      step();
    end
    check("drain_empty", count, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_checks = 0;  n_errors = 0;
    rst = 1;  rdy = 1;  new_en = 0;  new_tag = 0;  new_op = 7'd13;  new_vj = 0;  new_vk = 0;
    new_imm = 0;  new_qj = ND;  new_qk = ND;  cdb_en = 0;  cdb_idx = 0;  cdb_data = 0;
    rob_head = ND;  flush = 0;  reply_en = 0;  reply_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 0;

    // lw with ready operands
    dispatch(7'd13, 3'd1, 32'h100, 32'h0, 32'h4, ND, ND);
    step();
    check("t1_count", count, 1);
    step();
    check("t1_addr", mem_query_addr, 32'h104);
    check("t1_width", mem_data_width, 2);
    reply(32'hDEADBEEF);
    step();
    check("t1_wen", RoB_write_en, 1);
    check("t1_data", RoB_write_data, 32'hDEADBEEF);
    check("t1_count0", count, 0);

    // width and extension
    run_load("t2_lb", 7'd11, 32'h80, 32'hFFFFFF80);
    run_load("t2_lbu", 7'd14, 32'h80, 32'h00000080);
    run_load("t2_lh", 7'd12, 32'h8001, 32'hFFFF8001);
    run_load("t2_lhu", 7'd15, 32'h8001, 32'h00008001);

    // store waits for CDB data and for commit
    dispatch(7'd18, 3'd2, 32'h200, 32'h0, 32'h8, ND, 4'd3);
    step();
    cdb_en = 1;  cdb_idx = 3'd3;  cdb_data = 32'h55;
    step();
    step();
    step();
    check("t3_hold", mem_query_en, 0);
    rob_head = 4'd2;
    step();
    rob_head = ND;
    check("t3_type", mem_query_type, 1);
    check("t3_addr", mem_query_addr, 32'h208);
    check("t3_data", mem_query_data, 32'h55);
    reply(32'h0);
    step();
    check("t3_wdata", RoB_write_data, 32'h0);

    // fill, full rejection, pop/enqueue, tail wrap
    for (int i = 0; i < 8; i++) begin
      dispatch(7'd13, 3'(i), 32'(i * 16), 32'h0, 32'h0, 4'd7, ND);
      step();
    end
    check("t4_full", isFull, 1);
    dispatch(7'd11, 3'd0, 32'h0, 32'h0, 32'h0, ND, ND);
    step();
    check("t4_reject", count, 8);
    cdb_en = 1;  cdb_idx = 3'd7;  cdb_data = 32'h1000;
    step();
    step();
    check("t4_issue", mem_query_addr, 32'h1000);
    reply(32'h1);
    dispatch(7'd13, 3'd6, 32'h2000, 32'h0, 32'h0, ND, ND);
    step();
    check("t4_pop_full", count, 7);
    step();
    reply(32'h2);
    dispatch(7'd13, 3'd6, 32'h3000, 32'h0, 32'h0, ND, ND);
    step();
    check("t4_pop_enq", count, 7);
    dispatch(7'd12, 3'd4, 32'h4000, 32'h0, 32'h2, ND, ND);
    step();
    check("t4_refill", count, 8);
    drain();

    // flush with a load outstanding
    dispatch(7'd13, 3'd3, 32'h300, 32'h0, 32'h0, ND, ND);
    step();
    step();
    flush = 1;
    step();
    check("t5_held", mem_query_en, 1);
    dispatch(7'd13, 3'd4, 32'h400, 32'h0, 32'h0, ND, ND);
    step();
    check("t5_no_issue", mem_query_addr, 32'h300);
    reply(32'h1234);
    step();
    check("t5_no_write", RoB_write_en, 0);
    step();
    check("t5_next", mem_query_addr, 32'h400);
    reply(32'h5678);
    step();

    // asynchronous reset while waiting
    dispatch(7'd13, 3'd1, 32'h500, 32'h0, 32'h0, ND, ND);
    step();
    step();
    #1 rst = 1;
    #1 check("t6_async", mem_query_en, 0);
    check("t6_count", count, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    check_outputs();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(9) != 0);
      new_en = $urandom_range(1);
      new_op = 7'(11 + $urandom_range(7));
      new_tag = 3'($urandom);
      new_vj = $urandom;
      new_vk = $urandom;
      new_imm = $urandom;
      new_qj = ($urandom_range(3) == 0) ? 4'($urandom_range(7)) : ND;
      new_qk = ($urandom_range(3) == 0) ? 4'($urandom_range(7)) : ND;
      cdb_en = ($urandom_range(2) == 0);
      cdb_idx = 3'($urandom);
      cdb_data = $urandom;
      rob_head = (mq.size() > 0 && $urandom_range(1) == 1) ? {1'b0, mq[0].tag} : ND;
      reply_en = m_busy && rdy && ($urandom_range(2) == 0);
      reply_data = $urandom;
      if (reply_en && !m_drain) begin
        if (wid(mq[0].op) == 2'd0) reply_data = reply_data & 32'hFF;
        else if (wid(mq[0].op) == 2'd1) reply_data = reply_data & 32'hFFFF;
      end
      flush = !reply_en && ($urandom_range(39) == 0);
      step();
    end
    rdy = 1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
